// File: rtl/pipe_chain_if.sv
// Valid/ready bundle for pipe_chain: upstream (in_*) and downstream (out_*) handshakes.
// slave is the chain's view; master is the surrounding producer/consumer view.
interface pipe_chain_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/pipe_chain.sv
// DEPTH-stage valid/ready register chain with bubble collapsing, flush and occupancy.
// Optional statistics counters are built only when PIPE_CHAIN_STATS_EN is defined.
module pipe_chain #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int OCC_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   pipe_chain_if.slave      bus,
   input  logic             flush,
   output logic [OCC_W-1:0] occupancy,
   output logic [31:0]      stat_in_cnt,
   output logic [31:0]      stat_out_cnt,
   output logic [31:0]      stat_stall_cnt
);
   logic [DEPTH-1:0] v_reg;
   logic [DEPTH-1:0] v_next;
   logic [DEPTH-1:0] src_v;
   logic [WIDTH-1:0] d_reg [DEPTH];
   logic [WIDTH-1:0] src_d [DEPTH];
   logic             rdy [DEPTH];
   logic [OCC_W-1:0] occ_reg;
   logic [OCC_W-1:0] occ_next;
   logic             in_fire;

   assign bus.in_ready  = rdy[0] && !flush;
   assign in_fire       = bus.in_valid && bus.in_ready;
   assign bus.out_valid = v_reg[DEPTH-1];
   assign bus.out_data  = d_reg[DEPTH-1];
   assign occupancy     = occ_reg;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         // A stage can take a new word if it is empty or everything ahead of it moves.
         if (gi == DEPTH - 1) begin : g_last
            assign rdy[gi] = !v_reg[gi] || bus.out_ready;
         end else begin : g_mid
            assign rdy[gi] = !v_reg[gi] || rdy[gi+1];
         end

         if (gi == 0) begin : g_head
            assign src_v[gi] = in_fire;
            assign src_d[gi] = bus.in_data;
         end else begin : g_body
            assign src_v[gi] = v_reg[gi-1];
            assign src_d[gi] = d_reg[gi-1];
         end

         assign v_next[gi] = !flush && (rdy[gi] ? src_v[gi] : v_reg[gi]);
      end
   endgenerate

   always_comb begin
      occ_next = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occ_next = occ_next + OCC_W'(v_next[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_reg   <= '0;
         occ_reg <= '0;
      end else begin
         v_reg   <= v_next;
         occ_reg <= occ_next;
      end
   end

   // Data only moves when a valid word moves, so empty stages keep stale contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            d_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (rdy[i] && src_v[i]) begin
               d_reg[i] <= src_d[i];
            end
         end
      end
   end

`ifdef PIPE_CHAIN_STATS_EN
   logic [31:0] in_cnt_reg;
   logic [31:0] out_cnt_reg;
   logic [31:0] stall_cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_cnt_reg    <= '0;
         out_cnt_reg   <= '0;
         stall_cnt_reg <= '0;
      end else begin
         if (in_fire) begin
            in_cnt_reg <= in_cnt_reg + 32'd1;
         end
         if (bus.out_valid && bus.out_ready) begin
            out_cnt_reg <= out_cnt_reg + 32'd1;
         end
         if (bus.out_valid && !bus.out_ready) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
         end
      end
   end

   assign stat_in_cnt    = in_cnt_reg;
   assign stat_out_cnt   = out_cnt_reg;
   assign stat_stall_cnt = stall_cnt_reg;
`else
   assign stat_in_cnt    = '0;
   assign stat_out_cnt   = '0;
   assign stat_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_chain.sv
// Self-checking bench for pipe_chain: directed scenarios plus randomized traffic against
// a queue model in which the oldest word becomes visible DEPTH-1 edges after its acceptance.
`timescale 1ns/1ps
module tb_pipe_chain;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rst1_n;
   logic        flush;
   logic        flush1;
   logic [2:0]  occupancy;
   logic [0:0]  occ1;
   logic [31:0] s_in, s_out, s_stall;
   logic [31:0] s1_in, s1_out, s1_stall;

   pipe_chain_if #(.WIDTH(32)) bus ();
   pipe_chain_if #(.WIDTH(8))  bus1 ();

   pipe_chain #(.WIDTH(32), .DEPTH(DEPTH)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus),
      .flush          (flush),
      .occupancy      (occupancy),
      .stat_in_cnt    (s_in),
      .stat_out_cnt   (s_out),
      .stat_stall_cnt (s_stall)
   );

   pipe_chain #(.WIDTH(8), .DEPTH(1)) u_dut1 (
      .clk            (clk),
      .rst_n          (rst1_n),
      .bus            (bus1),
      .flush          (flush1),
      .occupancy      (occ1),
      .stat_in_cnt    (s1_in),
      .stat_out_cnt   (s1_out),
      .stat_stall_cnt (s1_stall)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: words in acceptance order, with the edge number at which each was taken.
   logic [31:0] mq_data [$];
   int          mq_time [$];
   int          edge_no = 0;
   int          m_in = 0, m_out = 0, m_stall = 0;

   logic        obs_ir, obs_ov;
   logic [31:0] obs_od;
   int          obs_occ;
   logic        exp_ir, exp_ov;
   logic [31:0] exp_od;
   int          exp_occ;

   task automatic model_clear();
      mq_data.delete();
      mq_time.delete();
   endtask

   // Called at a falling edge; drives one cycle, samples the DUT, advances the model.
   task automatic cycle(input logic iv, input logic [31:0] id, input logic ordy, input logic fl);
      bus.in_valid  = iv;
      bus.in_data   = id;
      bus.out_ready = ordy;
      flush         = fl;
      #1;
      obs_ir  = bus.in_ready;
      obs_ov  = bus.out_valid;
      obs_od  = bus.out_data;
      obs_occ = int'(occupancy);
      exp_ir  = ((mq_data.size() < DEPTH) || ordy) && !fl;
      exp_ov  = (mq_data.size() > 0) && ((edge_no - mq_time[0]) >= DEPTH - 1);
      exp_od  = (mq_data.size() > 0) ? mq_data[0] : 32'd0;
      exp_occ = mq_data.size();
      if (exp_ov && ordy) begin
         void'(mq_data.pop_front());
         void'(mq_time.pop_front());
         m_out++;
      end
      if (exp_ov && !ordy) m_stall++;
      if (fl) begin
         model_clear();
      end else if (iv && exp_ir) begin
         mq_data.push_back(id);
         mq_time.push_back(edge_no + 1);
         m_in++;
      end
      @(posedge clk);
      edge_no++;
      @(negedge clk);
   endtask

   task automatic test_reset();
      bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0; flush = 0;
      bus1.in_valid = 0; bus1.in_data = 0; bus1.out_ready = 0; flush1 = 0;
      rst_n = 0; rst1_n = 0;
      #14;
      rst_n = 1; rst1_n = 1;
      @(negedge clk);
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
      checks++; if (bus.out_data !== 32'd0) begin failures++; $display("FAIL reset_out_data got=%0h exp=0", bus.out_data); end
      checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
      checks++; if ({s_in, s_out, s_stall} !== 96'd0) begin failures++; $display("FAIL reset_stats got=%0d/%0d/%0d exp=0/0/0", s_in, s_out, s_stall); end
      @(negedge clk);
      model_clear();
      m_in = 0; m_out = 0; m_stall = 0;
   endtask

   task automatic test_latency();
      logic [31:0] ins [4]  = '{32'd9, 32'd2, 32'd0, 32'd13};
      logic        ivs [4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
      logic        e_v [10] = '{0, 0, 0, 0, 1, 1, 0, 1, 0, 0};
      logic [31:0] e_d [10] = '{0, 0, 0, 0, 9, 2, 0, 13, 0, 0};
      for (int c = 0; c < 10; c++) begin
         cycle(c < 4 ? ivs[c] : 1'b0, c < 4 ? ins[c] : 32'd0, 1'b1, 1'b0);
         checks++; if (obs_ov !== e_v[c]) begin failures++; $display("FAIL latency_valid c=%0d got=%0b exp=%0b", c, obs_ov, e_v[c]); end
         if (e_v[c]) begin
            checks++; if (obs_od !== e_d[c]) begin failures++; $display("FAIL latency_data c=%0d got=%0d exp=%0d", c, obs_od, e_d[c]); end
         end
         checks++; if (obs_occ > 3) begin failures++; $display("FAIL latency_occ c=%0d got=%0d exp<=3", c, obs_occ); end
      end
   endtask

   task automatic test_backpressure();
      int nxt = 1;
      int exp_out = 1;
      logic [31:0] stall0;
      stall0 = s_stall;
      for (int c = 0; c < 8; c++) begin
         cycle(nxt <= 6, 32'(nxt), 1'b0, 1'b0);
         checks++; if (obs_ir !== (c < 4)) begin failures++; $display("FAIL bp_in_ready c=%0d got=%0b exp=%0b", c, obs_ir, (c < 4)); end
         if (exp_ir && nxt <= 6) nxt++;
      end
      checks++; if (obs_occ != 4) begin failures++; $display("FAIL bp_occupancy got=%0d exp=4", obs_occ); end
`ifdef PIPE_CHAIN_STATS_EN
      checks++; if (s_stall - stall0 !== 32'd4) begin failures++; $display("FAIL bp_stall_cnt got=%0d exp=4", s_stall - stall0); end
`else
      checks++; if (s_stall !== 32'd0) begin failures++; $display("FAIL bp_stall_cnt got=%0d exp=0", s_stall); end
`endif
      for (int c = 0; c < 12; c++) begin
         cycle(nxt <= 6, 32'(nxt), 1'b1, 1'b0);
         if (exp_ir && nxt <= 6) nxt++;
         checks++; if (obs_ov !== exp_ov) begin failures++; $display("FAIL bp_out_valid c=%0d got=%0b exp=%0b", c, obs_ov, exp_ov); end
         if (obs_ov) begin
            checks++; if (obs_od !== 32'(exp_out)) begin failures++; $display("FAIL bp_order c=%0d got=%0d exp=%0d", c, obs_od, exp_out); end
            exp_out++;
         end
      end
      checks++; if (exp_out != 7) begin failures++; $display("FAIL bp_delivered got=%0d exp=6", exp_out - 1); end
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 4; c++) cycle(1'b1, $urandom, 1'b0, 1'b0);
      for (int c = 0; c < 10; c++) begin
         cycle(1'b1, $urandom, 1'b1, 1'b0);
         checks++; if (obs_ir !== 1'b1) begin failures++; $display("FAIL b2b_in_ready c=%0d got=%0b exp=1", c, obs_ir); end
         checks++; if (obs_ov !== 1'b1) begin failures++; $display("FAIL b2b_out_valid c=%0d got=%0b exp=1", c, obs_ov); end
         checks++; if (obs_occ != 4) begin failures++; $display("FAIL b2b_occupancy c=%0d got=%0d exp=4", c, obs_occ); end
         checks++; if (obs_od !== exp_od) begin failures++; $display("FAIL b2b_data c=%0d got=%0h exp=%0h", c, obs_od, exp_od); end
      end
   endtask

   task automatic test_flush();
      logic [31:0] in0;
      int          seen = 0;
      for (int c = 0; c < 6; c++) begin
         cycle(1'b0, 32'd0, 1'b1, 1'b0);
         if (exp_ov) begin
            checks++; if (obs_od !== exp_od) begin failures++; $display("FAIL flush_drain c=%0d got=%0h exp=%0h", c, obs_od, exp_od); end
         end
      end
      for (int c = 0; c < 3; c++) cycle(1'b1, 32'hF000 + 32'(c), 1'b0, 1'b0);
      in0 = s_in;
      cycle(1'b1, 32'hDEAD, 1'b0, 1'b1);
      checks++; if (obs_ir !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%0b exp=0", obs_ir); end
      checks++; if (obs_occ != 3) begin failures++; $display("FAIL flush_occ_before got=%0d exp=3", obs_occ); end
      checks++; if (s_in !== in0) begin failures++; $display("FAIL flush_stat_in got=%0d exp=%0d", s_in, in0); end
      for (int c = 0; c < 6; c++) begin
         cycle(c == 0, 32'hA5A5, 1'b1, 1'b0);
         if (c == 0) begin
            checks++; if (obs_occ != 0) begin failures++; $display("FAIL flush_occ_after got=%0d exp=0", obs_occ); end
         end
         if (obs_ov) begin
            checks++; if (obs_od !== 32'hA5A5) begin failures++; $display("FAIL flush_leak got=%0h exp=a5a5", obs_od); end
            seen++;
         end
      end
      checks++; if (seen != 1) begin failures++; $display("FAIL flush_new_word got=%0d words exp=1", seen); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         cycle($urandom_range(99) < 60, $urandom, $urandom_range(99) < 65, $urandom_range(99) < 3);
         checks++; if (obs_ir !== exp_ir) begin failures++; $display("FAIL rnd_in_ready c=%0d got=%0b exp=%0b", c, obs_ir, exp_ir); end
         checks++; if (obs_ov !== exp_ov) begin failures++; $display("FAIL rnd_out_valid c=%0d got=%0b exp=%0b", c, obs_ov, exp_ov); end
         checks++; if (obs_occ != exp_occ) begin failures++; $display("FAIL rnd_occupancy c=%0d got=%0d exp=%0d", c, obs_occ, exp_occ); end
         if (exp_ov) begin
            checks++; if (obs_od !== exp_od) begin failures++; $display("FAIL rnd_data c=%0d got=%0h exp=%0h", c, obs_od, exp_od); end
         end
      end
   endtask

   task automatic test_stats();
`ifdef PIPE_CHAIN_STATS_EN
      checks++; if (s_in !== 32'(m_in)) begin failures++; $display("FAIL stat_in got=%0d exp=%0d", s_in, m_in); end
      checks++; if (s_out !== 32'(m_out)) begin failures++; $display("FAIL stat_out got=%0d exp=%0d", s_out, m_out); end
      checks++; if (s_stall !== 32'(m_stall)) begin failures++; $display("FAIL stat_stall got=%0d exp=%0d", s_stall, m_stall); end
`else
      checks++; if ({s_in, s_out, s_stall} !== 96'd0) begin failures++; $display("FAIL stat_tied got=%0d/%0d/%0d exp=0/0/0", s_in, s_out, s_stall); end
      checks++; if ({s1_in, s1_out, s1_stall} !== 96'd0) begin failures++; $display("FAIL stat1_tied got=%0d/%0d/%0d exp=0/0/0", s1_in, s1_out, s1_stall); end
`endif
   endtask

   task automatic test_depth1();
      bus1.in_valid = 1; bus1.in_data = 8'h3C; bus1.out_ready = 0;
      #1;
      checks++; if (bus1.in_ready !== 1'b1) begin failures++; $display("FAIL d1_in_ready_empty got=%0b exp=1", bus1.in_ready); end
      @(posedge clk);
      @(negedge clk);
      bus1.in_valid = 0;
      #1;
      checks++; if (bus1.out_valid !== 1'b1) begin failures++; $display("FAIL d1_out_valid got=%0b exp=1", bus1.out_valid); end
      checks++; if (bus1.out_data !== 8'h3C) begin failures++; $display("FAIL d1_out_data got=%0h exp=3c", bus1.out_data); end
      checks++; if (bus1.in_ready !== 1'b0) begin failures++; $display("FAIL d1_in_ready_full got=%0b exp=0", bus1.in_ready); end
      bus1.out_ready = 1;
      #1;
      checks++; if (bus1.in_ready !== 1'b1) begin failures++; $display("FAIL d1_in_ready_drain got=%0b exp=1", bus1.in_ready); end
      bus1.out_ready = 0;
      #1;
      rst1_n = 0;
      #1;
      checks++; if (bus1.out_valid !== 1'b0) begin failures++; $display("FAIL d1_async_reset got=%0b exp=0", bus1.out_valid); end
      checks++; if (occ1 !== 1'b0) begin failures++; $display("FAIL d1_async_occ got=%0d exp=0", occ1); end
      checks++; if ({s1_in, s1_out, s1_stall} !== 96'd0) begin failures++; $display("FAIL d1_stats got=%0d/%0d/%0d exp=0/0/0", s1_in, s1_out, s1_stall); end
      @(negedge clk);
      rst1_n = 1;
   endtask

   initial begin
      test_reset();
      test_latency();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_random();
      test_stats();
      test_depth1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
